// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle signed multiply / divide unit for the EX stage. Operands are
//   converted to magnitudes and processed one bit per cycle (shift-add for
//   multiply, restoring division for divide). A final cycle restores the
//   signs, and the 64-bit result is written to hi/lo.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   operation request, sampled only when idle
//   op       in   0 = signed multiply, 1 = signed divide
//   a        in   multiplicand / dividend (signed)
//   b        in   multiplier / divisor (signed)
//   busy     out  operation in progress (through the done cycle)
//   done     out  one-cycle pulse when hi/lo are updated
//   divzero  out  divide had b = 0; valid with done, cleared on next start
//   hi       out  product[63:32] or remainder
//   lo       out  product[31:0] or quotient
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               dz_r;

    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic               sa;
    logic               sb;
    logic               op_r;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Conditional two's-complement negate; -2^31 maps to itself, which is
    // exactly the unsigned magnitude 0x80000000 we want for that operand.
    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x,
                                              input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x,
                                                 input logic n);
        return n ? -x : x;
    endfunction

    // One shift-add step. The low half starts as the multiplier and is shifted
    // out LSB first while product bits shift in from the top.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_in,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, mcand} : '0);
        return {sum, acc_in[WIDTH-1:1]};
    endfunction

    // One restoring-division step on {remainder, dividend/quotient}. The
    // shifted remainder needs WIDTH+1 bits because the divisor may be 2^31.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc_in,
                                                    input logic [WIDTH-1:0]   dvsr);
        logic [WIDTH:0]   rem_sh;
        logic [WIDTH+1:0] diff;
        rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
        diff   = {1'b0, rem_sh} - {2'b00, dvsr};
        if (!diff[WIDTH+1])
            return {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
        else
            return {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    endfunction

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dz_r    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt     <= '0;
                        divzero <= 1'b0;
                        if (op && b == '0) begin
                            // No iterations needed; busy is raised only
                            // for the done cycle.
                            dz_r  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            dz_r  <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                end
                DONE: begin
                    hi      <= res_hi;
                    lo      <= res_lo;
                    done    <= 1'b1;
                    busy    <= 1'b1;
                    divzero <= dz_r;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    ma   <= cneg(a, a[WIDTH-1]);
                    mb   <= cneg(b, b[WIDTH-1]);
                    sa   <= a[WIDTH-1];
                    sb   <= b[WIDTH-1];
                    op_r <= op;
                    acc  <= op ? {{WIDTH{1'b0}}, cneg(a, a[WIDTH-1])}
                               : {{WIDTH{1'b0}}, cneg(b, b[WIDTH-1])};
                    if (op && b == '0) begin
                        res_hi <= a;
                        res_lo <= '1;
                    end
                end
            end
            RUN: begin
                acc <= op_r ? div_step(acc, mb) : mul_step(acc, ma);
            end
            FIX: begin
                // Truncating division: quotient sign = sa^sb, remainder
                // follows the dividend.
                if (op_r) begin
                    res_lo <= cneg(acc[WIDTH-1:0], sa ^ sb);
                    res_hi <= cneg(acc[2*WIDTH-1:WIDTH], sa);
                end else begin
                    {res_hi, res_lo} <= cneg2(acc, sa ^ sb);
                end
            end
            default: ;
        endcase
    end

endmodule
